// File: rtl/gdo_mac_stream_if.sv
// gdo_mac_stream_if: operand-pair input stream and result output stream of the gdo MAC engine.
interface gdo_mac_stream_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
);
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;

    modport master (
        output cfg_len, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  cfg_len, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/gdo_mac_stream.sv
// gdo_mac_stream: streaming fixed-point dot product (multiply stage, accumulate stage, one result per vector).
// Define GDO_MAC_SAT_EN to clamp overflowed products/sums instead of wrapping.
module gdo_mac_stream #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    gdo_mac_stream_if.slave   s
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            st_q, st_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic              dn_q, dn_d, pv_q, pv_d, povf_q, povf_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] prod_q, prod_d, acc_q, acc_d;

    logic                      fire, take;
    logic [2*DATA_W-1:0]       p;
    logic [DATA_W-FRAC_W:0]    p_hi;
    logic                      p_ov, s_ov;
    logic [DATA_W-1:0]         p_val, sum, sum_val;

    assign s.in_ready  = rst_n && (st_q == IDLE || st_q == ACCUM);
    assign s.out_valid = (st_q == OUT);
    assign s.out_data  = acc_q;
    assign s.out_ovf   = ovf_q;

    assign fire = s.in_valid && s.in_ready;
    assign take = (st_q == OUT) && s.out_ready;

    always_comb begin
        p     = {{DATA_W{s.in_a[DATA_W-1]}}, s.in_a} * {{DATA_W{s.in_b[DATA_W-1]}}, s.in_b};
        p_hi  = p[2*DATA_W-1 : DATA_W+FRAC_W-1];
        p_ov  = !((&p_hi) || !(|p_hi));
        sum   = acc_q + prod_q;
        s_ov  = (acc_q[DATA_W-1] == prod_q[DATA_W-1]) && (sum[DATA_W-1] != acc_q[DATA_W-1]);
`ifdef GDO_MAC_SAT_EN
        p_val   = p_ov ? (p[2*DATA_W-1] ? MIN_V : MAX_V) : p[DATA_W+FRAC_W-1 -: DATA_W];
        sum_val = s_ov ? (acc_q[DATA_W-1] ? MIN_V : MAX_V) : sum;
`else
        p_val   = p[DATA_W+FRAC_W-1 -: DATA_W];
        sum_val = sum;
`endif
    end

    // Stage 1 captures only handshaken pairs; stage 2 folds them into the accumulator.
    always_comb begin
        prod_d = fire ? p_val : prod_q;
        povf_d = fire && p_ov;
        pv_d   = fire;
        acc_d  = pv_q ? sum_val : (take ? '0 : acc_q);
        ovf_d  = pv_q ? (ovf_q || povf_q || s_ov) : (take ? 1'b0 : ovf_q);
    end

    always_comb begin
        st_d  = st_q;
        len_d = len_q;
        cnt_d = cnt_q;
        dn_d  = 1'b0;
        case (st_q)
            IDLE: if (fire) begin
                len_d = s.cfg_len;
                cnt_d = LEN_W'(1);
                st_d  = (s.cfg_len == LEN_W'(1)) ? DRAIN : ACCUM;
            end
            ACCUM: if (fire) begin
                cnt_d = cnt_q + LEN_W'(1);
                st_d  = (cnt_q == len_q - LEN_W'(1)) ? DRAIN : ACCUM;
            end
            DRAIN: begin
                dn_d = !dn_q;
                st_d = dn_q ? OUT : DRAIN;
            end
            OUT: st_d = s.out_ready ? IDLE : OUT;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            len_q  <= '0;
            cnt_q  <= '0;
            dn_q   <= 1'b0;
            pv_q   <= 1'b0;
            povf_q <= 1'b0;
            prod_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            dn_q   <= dn_d;
            pv_q   <= pv_d;
            povf_q <= povf_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_gdo_mac_stream.sv
// tb_gdo_mac_stream: directed scoreboard bench for the gdo MAC stream engine.
module tb_gdo_mac_stream;
    typedef struct packed {logic [15:0] d; logic o;} res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gdo_mac_stream_if #(.DATA_W(16), .LEN_W(8)) bus ();
    gdo_mac_stream #(.DATA_W(16), .FRAC_W(8), .LEN_W(8)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

    res_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] va[256];
    logic [15:0] vb[256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: Q8.8 multiply with floor truncation, then 16-bit accumulate.
    function automatic res_t model(input int n);
        logic [15:0] acc = 16'h0;
        logic        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic signed [31:0] pr;
            logic [15:0]        q, sm;
            logic               po, so;
            pr = $signed(va[i]) * $signed(vb[i]);
            q  = pr[23:8];
            po = !(pr[31:23] == 9'h1FF || pr[31:23] == 9'h000);
`ifdef GDO_MAC_SAT_EN
            if (po) q = pr[31] ? 16'h8000 : 16'h7FFF;
`endif
            sm = acc + q;
            so = (acc[15] == q[15]) && (sm[15] != acc[15]);
`ifdef GDO_MAC_SAT_EN
            if (so) sm = acc[15] ? 16'h8000 : 16'h7FFF;
`endif
            o   = o | po | so;
            acc = sm;
        end
        return '{d: acc, o: o};
    endfunction

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [7:0] l);
        int w = 0;
        bus.in_a = a; bus.in_b = b; bus.cfg_len = l; bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w == 50) chk("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a = 16'($urandom); bus.in_b = 16'($urandom); bus.cfg_len = 8'($urandom);
    endtask

    task automatic send_vec(input int n, input logic [7:0] l, input int gap_at, input int gap_len);
        sb.push_back(model(n));
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) repeat (gap_len) @(negedge clk);
            beat(va[i], vb[i], l);
        end
    endtask

    task automatic get_result(input string tag, input int stall);
        res_t e;
        int   w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w == 50) chk({tag, "_out_valid_timeout"}, 32'd0, 32'd1);
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall"}, {13'd0, bus.out_valid, bus.in_ready, bus.out_ovf, bus.out_data},
                {13'd0, 1'b1, 1'b0, e.o, e.d});
            @(negedge clk);
        end
        chk({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, e.d});
        chk({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, e.o});
        chk({tag, "_in_ready_out"}, {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_back_idle"}, {30'd0, bus.out_valid, bus.in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.cfg_len = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {13'd0, bus.in_ready, bus.out_valid, bus.out_ovf, bus.out_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // len=1, 1.0*2.0 with latency measurement
        va[0] = 16'h0100; vb[0] = 16'h0200;
        sb.push_back(model(1));
        chk("model_sanity_t1", {16'd0, sb[0].d}, 32'h0200);
        beat(va[0], vb[0], 8'd1);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", lat, 32'd3);
        get_result("t1", 0);

        // len=4 with a 2-cycle gap; in_ready must drop in DRAIN
        for (int i = 0; i < 4; i++) begin va[i] = 16'h0180; vb[i] = 16'h0200; end
        send_vec(4, 8'd4, 2, 2);
        chk("t2_in_ready_drain", {31'd0, bus.in_ready}, 32'd0);
        chk("t2_expected", {16'd0, sb[0].d}, 32'h0C00);
        get_result("t2", 0);

        // negative operand, with a 10-cycle output stall
        va[0] = 16'hFF00; vb[0] = 16'h0280;
        send_vec(1, 8'd1, -1, 0);
        chk("t3_expected", {15'd0, sb[0]}, {15'd0, 16'hFD80, 1'b0});
        get_result("t3", 10);

        // overflowing products
        va[0] = 16'h7F00; vb[0] = 16'h7F00; va[1] = 16'h7F00; vb[1] = 16'h7F00;
        send_vec(2, 8'd2, -1, 0);
        get_result("t4", 0);

        // reset mid-vector discards partial work
        va[0] = 16'h0100; vb[0] = 16'h0300; va[1] = 16'h0200; vb[1] = 16'h0100;
        beat(va[0], vb[0], 8'd4);
        beat(va[1], vb[1], 8'd4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        chk("t6_no_output", {31'd0, seen}, 32'd0);
        va[0] = 16'h0100; vb[0] = 16'h0100;
        send_vec(1, 8'd1, -1, 0);
        get_result("t6", 0);

        // random length-5 vector and a full 256-beat (cfg_len=0) vector
        for (int i = 0; i < 5; i++) begin va[i] = 16'($urandom_range(0, 16'h0400)) - 16'h0200; vb[i] = 16'($urandom); end
        send_vec(5, 8'd5, 3, 1);
        get_result("r5", 0);
        for (int i = 0; i < 256; i++) begin va[i] = 16'($urandom); vb[i] = 16'($urandom); end
        send_vec(256, 8'd0, -1, 0);
        get_result("r256", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
